me_unit: RTL and testbench

ME_UNIT -- requirements
Module: me_unit

---
 rtl/me_unit_pkg.sv | 48 ++++
 rtl/me_unit_lane.sv | 55 +++++
 rtl/me_unit.sv | 147 ++++++++++++++
 tb/tb_me_unit.sv | 431 ++++++++++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/me_unit_pkg.sv
// me_unit_pkg: shared constants for the memory stage.
//   - opcode / funct3 encodings recognised by me_unit
//   - op-class and FSM state encodings
//   - decode_cls(): opcode -> op class
package me_unit_pkg;

    localparam logic [6:0] OP_LOAD    = 7'b0000011;
    localparam logic [6:0] OP_STORE   = 7'b0100011;
    localparam logic [6:0] OP_LOADFP  = 7'b0000111;
    localparam logic [6:0] OP_STOREFP = 7'b0100111;
    localparam logic [6:0] OP_MLOAD   = 7'b0001011;
    localparam logic [6:0] OP_MSTORE  = 7'b0101011;

    localparam logic [2:0] F3_B  = 3'b000;
    localparam logic [2:0] F3_H  = 3'b001;
    localparam logic [2:0] F3_W  = 3'b010;
    localparam logic [2:0] F3_BU = 3'b100;
    localparam logic [2:0] F3_HU = 3'b101;

    localparam int MBEATS = 16;
    localparam int MW     = 32 * MBEATS;

    typedef enum logic [2:0] {
        CLS_PASS,
        CLS_LOAD,
        CLS_STORE,
        CLS_MLOAD,
        CLS_MSTORE
    } op_cls_t;

    typedef enum logic [1:0] {
        ST_IDLE,
        ST_BUSY,
        ST_HOLD
    } state_t;

    // FP loads/stores share the scalar path; only the store data source differs.
    function automatic op_cls_t decode_cls(input logic [6:0] op);
        case (op)
            OP_LOAD, OP_LOADFP:   return CLS_LOAD;
            OP_STORE, OP_STOREFP: return CLS_STORE;
            OP_MLOAD:             return CLS_MLOAD;
            OP_MSTORE:            return CLS_MSTORE;
            default:              return CLS_PASS;
        endcase
    endfunction

endpackage

// File: rtl/me_unit_lane.sv
// me_lane: combinational byte-lane logic for scalar memory ops.
//   funct3 : access size/sign (B/H/W/BU/HU)
//   off    : byte offset within the 32-bit word (address bits [1:0])
//   sdata  : store data (low bits significant)
//   rdata  : word returned by the data memory
//   wstrb  : byte strobes for the store
//   wdata  : store data replicated into every lane
//   ldata  : load result, extracted and sign/zero-extended
module me_lane
    import me_unit_pkg::*;
(
    input  logic [2:0]  funct3,
    input  logic [1:0]  off,
    input  logic [31:0] sdata,
    input  logic [31:0] rdata,
    output logic [3:0]  wstrb,
    output logic [31:0] wdata,
    output logic [31:0] ldata
);

    logic [7:0]  rbyte;
    logic [15:0] rhalf;

    // Halfword accesses ignore off[0].
    assign rbyte = rdata[{off, 3'b000} +: 8];
    assign rhalf = rdata[{off[1], 4'b0000} +: 16];

    always_comb begin
        wstrb = 4'b1111;
        wdata = sdata;
        case (funct3)
            F3_B: begin
                wstrb = 4'b0001 << off;
                wdata = {4{sdata[7:0]}};
            end
            F3_H: begin
                wstrb = 4'b0011 << {off[1], 1'b0};
                wdata = {2{sdata[15:0]}};
            end
            default: ;
        endcase
    end

    always_comb begin
        ldata = rdata;
        case (funct3)
            F3_B:    ldata = {{24{rbyte[7]}}, rbyte};
            F3_BU:   ldata = {24'd0, rbyte};
            F3_H:    ldata = {{16{rhalf[15]}}, rhalf};
            F3_HU:   ldata = {16'd0, rhalf};
            default: ;
        endcase
    end

endmodule

// File: rtl/me_unit.sv
// me_unit: memory stage between EX and WB.
//   clk, rst_n            : clock, synchronous active-low reset
//   EX_valid / ready      : op handshake from EX
//   opcode..rs2_M         : op fields and data from EX, captured on accept
//   dmem_*                : single-outstanding data memory port, beat done on req&&ack
//   valid / WB_ready      : result handshake toward WB
//   wb_*                  : WB payload, held stable while valid && !WB_ready
// Scalar ops take one memory beat, MLOAD/MSTORE take 16 consecutive word beats.
module me_unit
    import me_unit_pkg::*;
(
    input  logic           clk,
    input  logic           rst_n,
    input  logic           EX_valid,
    output logic           ready,
    input  logic [6:0]     opcode,
    input  logic [2:0]     funct3,
    input  logic [1:0]     rd_group,
    input  logic [4:0]     rd_index,
    input  logic [31:0]    npc,
    input  logic [31:0]    res_R,
    input  logic [31:0]    rs2_R,
    input  logic [31:0]    rs2_F,
    input  logic [MW-1:0]  res_M,
    input  logic [MW-1:0]  rs2_M,
    output logic           dmem_req,
    output logic           dmem_we,
    output logic [31:0]    dmem_addr,
    output logic [31:0]    dmem_wdata,
    output logic [3:0]     dmem_wstrb,
    input  logic           dmem_ack,
    input  logic [31:0]    dmem_rdata,
    output logic           valid,
    input  logic           WB_ready,
    output logic [31:0]    wb_npc,
    output logic [31:0]    wb_R,
    output logic [MW-1:0]  wb_M,
    output logic [1:0]     wb_rd_group,
    output logic [4:0]     wb_rd_index
);

    state_t          state;
    op_cls_t         cls;
    logic [3:0]      beat;
    logic [2:0]      f3;
    logic [31:0]     base;
    logic [31:0]     sdata;
    logic [MW-1:0]   mdata;

    logic            accept;
    logic            last_beat;
    op_cls_t         cls_in;
    logic [2:0]      f3_in;
    logic [3:0]      lane_wstrb;
    logic [31:0]     lane_wdata;
    logic [31:0]     lane_ldata;

    assign ready    = (state == ST_IDLE) || (state == ST_HOLD && WB_ready);
    assign valid    = (state == ST_HOLD);
    assign accept   = EX_valid && ready;
    assign dmem_req = (state == ST_BUSY);
    assign dmem_we  = (cls == CLS_STORE) || (cls == CLS_MSTORE);

    // Beat offset is added to the word-aligned base; the 32-bit sum wraps naturally.
    assign dmem_addr = {base[31:2], 2'b00} + {26'd0, beat, 2'b00};
    assign last_beat = !((cls == CLS_MLOAD) || (cls == CLS_MSTORE)) || (beat == 4'hF);

    // FP variants are word-only regardless of funct3.
    assign cls_in = decode_cls(opcode);
    assign f3_in  = (opcode == OP_LOADFP || opcode == OP_STOREFP) ? F3_W : funct3;

    me_lane u_lane (
        .funct3 (f3),
        .off    (base[1:0]),
        .sdata  (sdata),
        .rdata  (dmem_rdata),
        .wstrb  (lane_wstrb),
        .wdata  (lane_wdata),
        .ldata  (lane_ldata)
    );

    always_comb begin
        dmem_wstrb = 4'b0000;
        dmem_wdata = 32'd0;
        if (cls == CLS_MSTORE) begin
            dmem_wstrb = 4'b1111;
            dmem_wdata = mdata[{beat, 5'b00000} +: 32];
        end else if (cls == CLS_STORE) begin
            dmem_wstrb = lane_wstrb;
            dmem_wdata = lane_wdata;
        end
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state       <= ST_IDLE;
            cls         <= CLS_PASS;
            beat        <= 4'd0;
            f3          <= 3'd0;
            base        <= 32'd0;
            sdata       <= 32'd0;
            mdata       <= '0;
            wb_npc      <= 32'd0;
            wb_R        <= 32'd0;
            wb_M        <= '0;
            wb_rd_group <= 2'd0;
            wb_rd_index <= 5'd0;
        end else begin
            case (state)
                ST_IDLE, ST_HOLD: begin
                    if (accept) begin
                        cls         <= cls_in;
                        f3          <= f3_in;
                        base        <= res_R;
                        sdata       <= (opcode == OP_STOREFP) ? rs2_F : rs2_R;
                        mdata       <= rs2_M;
                        beat        <= 4'd0;
                        wb_npc      <= npc;
                        wb_R        <= res_R;
                        wb_M        <= (cls_in == CLS_PASS) ? res_M : '0;
                        wb_rd_group <= rd_group;
                        wb_rd_index <= rd_index;
                        state       <= (cls_in == CLS_PASS) ? ST_HOLD : ST_BUSY;
                    end else if (state == ST_HOLD && WB_ready) begin
                        state <= ST_IDLE;
                    end
                end
                ST_BUSY: begin
                    if (dmem_ack) begin
                        if (cls == CLS_MLOAD)
                            wb_M[{beat, 5'b00000} +: 32] <= dmem_rdata;
                        if (cls == CLS_LOAD)
                            wb_R <= lane_ldata;
                        // beat 15 + 1 wraps to 0, leaving the counter clean for the next op
                        beat <= beat + 4'd1;
                        if (last_beat) begin
                            beat  <= 4'd0;
                            state <= ST_HOLD;
                        end
                    end
                end
                default: state <= ST_IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_me_unit.sv
// tb_me_unit: randomized self-checking bench for me_unit with a transaction-level
// reference model (expected memory beats and WB results per accepted op).
module tb_me_unit;

    localparam logic [6:0] LD = 7'b0000011, ST = 7'b0100011, LDF = 7'b0000111;
    localparam logic [6:0] STF = 7'b0100111, MLD = 7'b0001011, MST = 7'b0101011;

    logic clk = 1'b0, rst_n = 1'b0, EX_valid = 1'b0;
    logic [6:0] opcode = '0;
    logic [2:0] funct3 = '0;
    logic [1:0] rd_group = '0;
    logic [4:0] rd_index = '0;
    logic [31:0] npc = '0, res_R = '0, rs2_R = '0, rs2_F = '0;
    logic [511:0] res_M = '0, rs2_M = '0;
    logic ready, dmem_req, dmem_we, valid;
    logic [31:0] dmem_addr, dmem_wdata, dmem_rdata;
    logic [3:0] dmem_wstrb;
    logic dmem_ack = 1'b0, WB_ready = 1'b1;
    logic [31:0] wb_npc, wb_R;
    logic [511:0] wb_M;
    logic [1:0] wb_rd_group;
    logic [4:0] wb_rd_index;

    me_unit dut (
        .clk(clk), .rst_n(rst_n), .EX_valid(EX_valid), .ready(ready),
        .opcode(opcode), .funct3(funct3), .rd_group(rd_group), .rd_index(rd_index),
        .npc(npc), .res_R(res_R), .rs2_R(rs2_R), .rs2_F(rs2_F), .res_M(res_M), .rs2_M(rs2_M),
        .dmem_req(dmem_req), .dmem_we(dmem_we), .dmem_addr(dmem_addr),
        .dmem_wdata(dmem_wdata), .dmem_wstrb(dmem_wstrb), .dmem_ack(dmem_ack),
        .dmem_rdata(dmem_rdata), .valid(valid), .WB_ready(WB_ready),
        .wb_npc(wb_npc), .wb_R(wb_R), .wb_M(wb_M), .wb_rd_group(wb_rd_group),
        .wb_rd_index(wb_rd_index)
    );

    always #5 clk = ~clk;

    int cyc = 0;
    int checks = 0, failures = 0;
    int ack_mode = 0;   // 0 always, 1 never, 2 alternate, 3 random
    int wb_mode = 0;    // 0 high, 1 low, 2 random

    initial forever begin
        @(posedge clk);
        cyc++;
    end

    // Static memory image: any address has a fixed content.
    function automatic logic [31:0] mem_rd(input logic [31:0] a);
        if (a == 32'h1000) return 32'h80000000;
        return (a * 32'h9E3779B1) ^ 32'h5A5A0F0F;
    endfunction

    assign dmem_rdata = mem_rd(dmem_addr);

    logic ack_tog = 1'b0;
    initial forever begin
        @(posedge clk);
        #2;
        case (ack_mode)
            0: dmem_ack = 1'b1;
            1: dmem_ack = 1'b0;
            2: begin ack_tog = ~ack_tog; dmem_ack = ack_tog; end
            default: dmem_ack = 1'($urandom_range(0, 1));
        endcase
        case (wb_mode)
            0: WB_ready = 1'b1;
            1: WB_ready = 1'b0;
            default: WB_ready = 1'($urandom_range(0, 1));
        endcase
    end

    task automatic chk(input string nm, input logic [511:0] act, input logic [511:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s: got %0h expected %0h", nm, act, exp);
        end
    endtask

    // ---------------- reference model ----------------
    typedef struct {
        logic [31:0] addr;
        logic        we;
        logic [3:0]  wstrb;
        logic [31:0] wdata;
    } beat_t;

    typedef struct {
        logic [31:0]  npc;
        logic [31:0]  r;
        logic [511:0] m;
        logic [1:0]   grp;
        logic [4:0]   idx;
        logic         chk_r;
    } res_t;

    beat_t bq[$];
    res_t  rq[$];

    task automatic model_push();
        logic [31:0] base, w, d, a;
        logic [7:0]  b;
        logic [15:0] h;
        int off, f;
        res_t r;
        beat_t bt;
        base = res_R & 32'hFFFFFFFC;
        off  = int'(res_R[1:0]);
        r.npc = npc; r.r = res_R; r.m = '0; r.grp = rd_group; r.idx = rd_index; r.chk_r = 1'b1;
        case (opcode)
            LD, LDF: begin
                f = (opcode == LDF) ? 2 : int'(funct3);
                w = mem_rd(base);
                b = 8'(w >> (8 * off));
                h = 16'(w >> (16 * (off / 2)));
                case (f)
                    0: r.r = 32'(b) - (b >= 8'd128 ? 32'd256 : 32'd0);
                    4: r.r = 32'(b);
                    1: r.r = 32'(h) - (h >= 16'd32768 ? 32'd65536 : 32'd0);
                    5: r.r = 32'(h);
                    default: r.r = w;
                endcase
                bt.addr = base; bt.we = 1'b0; bt.wstrb = '0; bt.wdata = '0;
                bq.push_back(bt);
            end
            ST, STF: begin
                f = (opcode == STF) ? 2 : int'(funct3);
                d = (opcode == STF) ? rs2_F : rs2_R;
                bt.addr = base; bt.we = 1'b1;
                if (f == 0) begin
                    bt.wstrb = 4'(1 << off); bt.wdata = 32'(d[7:0]) * 32'h01010101;
                end else if (f == 1) begin
                    bt.wstrb = 4'(3 << (2 * (off / 2))); bt.wdata = 32'(d[15:0]) * 32'h00010001;
                end else begin
                    bt.wstrb = 4'hF; bt.wdata = d;
                end
                bq.push_back(bt);
            end
            MLD: begin
                r.chk_r = 1'b0;
                for (int k = 0; k < 16; k++) begin
                    a = base + 32'(4 * k);
                    r.m[32*k +: 32] = mem_rd(a);
                    bt.addr = a; bt.we = 1'b0; bt.wstrb = '0; bt.wdata = '0;
                    bq.push_back(bt);
                end
            end
            MST: begin
                for (int k = 0; k < 16; k++) begin
                    bt.addr = base + 32'(4 * k); bt.we = 1'b1; bt.wstrb = 4'hF;
                    bt.wdata = rs2_M[32*k +: 32];
                    bq.push_back(bt);
                end
            end
            default: r.m = res_M;
        endcase
        rq.push_back(r);
    endtask

    // ---------------- compare process ----------------
    logic  req_wait = 1'b0, hold_prev = 1'b0;
    beat_t req_save;
    res_t  wb_save;

    initial forever begin
        @(negedge clk);
        if (!rst_n) begin
            bq.delete(); rq.delete();
            req_wait = 1'b0; hold_prev = 1'b0;
        end else begin
            if (dmem_req && req_wait) begin
                chk("req_stable_addr", 512'(dmem_addr), 512'(req_save.addr));
                chk("req_stable_wd", 512'({dmem_we, dmem_wstrb, dmem_wdata}),
                    512'({req_save.we, req_save.wstrb, req_save.wdata}));
            end
            if (dmem_req && dmem_ack) begin
                if (bq.size() == 0) begin
                    chk("unexpected_beat", 512'(dmem_addr), 512'(0));
                    chk("unexpected_beat_q", 512'(1), 512'(0));
                end else begin
                    beat_t e;
                    e = bq.pop_front();
                    chk("beat_addr", 512'(dmem_addr), 512'(e.addr));
                    chk("beat_we", 512'(dmem_we), 512'(e.we));
                    if (e.we) begin
                        chk("beat_wstrb", 512'(dmem_wstrb), 512'(e.wstrb));
                        chk("beat_wdata", 512'(dmem_wdata), 512'(e.wdata));
                    end
                end
            end
            req_wait = dmem_req && !dmem_ack;
            req_save.addr = dmem_addr; req_save.we = dmem_we;
            req_save.wstrb = dmem_wstrb; req_save.wdata = dmem_wdata;

            if (hold_prev && valid) begin
                chk("wb_stable_R", 512'({wb_npc, wb_R, wb_rd_group, wb_rd_index}),
                    512'({wb_save.npc, wb_save.r, wb_save.grp, wb_save.idx}));
                chk("wb_stable_M", wb_M, wb_save.m);
            end
            if (valid && !WB_ready) chk("ready_in_hold", 512'(ready), 512'(0));
            if (valid && WB_ready) begin
                if (rq.size() == 0) begin
                    chk("unexpected_valid", 512'(1), 512'(0));
                end else begin
                    res_t e;
                    e = rq.pop_front();
                    chk("wb_npc", 512'(wb_npc), 512'(e.npc));
                    if (e.chk_r) chk("wb_R", 512'(wb_R), 512'(e.r));
                    chk("wb_M", wb_M, e.m);
                    chk("wb_rd", 512'({wb_rd_group, wb_rd_index}), 512'({e.grp, e.idx}));
                end
            end
            hold_prev = valid && !WB_ready;
            wb_save.npc = wb_npc; wb_save.r = wb_R; wb_save.m = wb_M;
            wb_save.grp = wb_rd_group; wb_save.idx = wb_rd_index;

            if (EX_valid && ready) model_push();
        end
    end

    // ---------------- stimulus helpers ----------------
    task automatic rand_fields();
        npc = $urandom; rd_group = 2'($urandom); rd_index = 5'($urandom);
        res_R = $urandom; rs2_R = $urandom; rs2_F = $urandom;
        funct3 = 3'($urandom);
        for (int k = 0; k < 16; k++) begin
            res_M[32*k +: 32] = $urandom;
            rs2_M[32*k +: 32] = $urandom;
        end
    endtask

    task automatic rand_op();
        logic [6:0] o;
        rand_fields();
        case ($urandom_range(0, 6))
            0: begin
                o = 7'($urandom);
                if (o inside {LD, ST, LDF, STF, MLD, MST}) o = 7'b0110011;
                opcode = o;
            end
            1: begin
                opcode = LD;
                case ($urandom_range(0, 4))
                    0: funct3 = 3'd0; 1: funct3 = 3'd1; 2: funct3 = 3'd2;
                    3: funct3 = 3'd4; default: funct3 = 3'd5;
                endcase
            end
            2: begin opcode = ST; funct3 = 3'($urandom_range(0, 2)); end
            3: begin opcode = LDF; funct3 = 3'd2; end
            4: begin opcode = STF; funct3 = 3'd2; end
            5: opcode = MLD;
            default: opcode = MST;
        endcase
    endtask

    // Holds EX_valid until accepted; returns the accept cycle index.
    task automatic send(output int acc);
        acc = -1;
        EX_valid = 1'b1;
        for (int i = 0; i < 400; i++) begin
            @(negedge clk);
            if (ready) begin acc = cyc; break; end
        end
        if (acc < 0) chk("accept_timeout", 512'(0), 512'(1));
        @(posedge clk);
        #1;
        EX_valid = 1'b0;
    endtask

    task automatic wait_valid(output int vc);
        vc = -1;
        for (int i = 0; i < 400; i++) begin
            @(negedge clk);
            if (valid) begin vc = cyc; break; end
        end
        if (vc < 0) chk("valid_timeout", 512'(0), 512'(1));
    endtask

    initial begin
        #2000000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1, "watchdog");
    end

    // ---------------- main sequence ----------------
    initial begin
        int acc, vc, n;
        logic [31:0] addrs[16];
        logic seen;

        repeat (3) @(posedge clk);
        @(negedge clk);
        chk("rst_ready", 512'(ready), 512'(1));
        chk("rst_valid", 512'(valid), 512'(0));
        chk("rst_req", 512'(dmem_req), 512'(0));
        chk("rst_wb", 512'({wb_npc, wb_R, wb_rd_group, wb_rd_index}), 512'(0));
        chk("rst_wbM", wb_M, 512'(0));
        @(posedge clk); #1 rst_n = 1'b1;

        // PASS op, one-cycle latency
        rand_fields(); opcode = 7'b0110011; res_R = 32'h12345678;
        send(acc); wait_valid(vc);
        chk("pass_latency", 512'(vc - acc), 512'(1));
        chk("pass_wbR", 512'(wb_R), 512'(32'h12345678));
        chk("pass_no_req", 512'(dmem_req), 512'(0));

        // SB at byte 3
        @(posedge clk); #1;
        rand_fields(); opcode = ST; funct3 = 3'd0; rs2_R = 32'hAB; res_R = 32'h1003;
        send(acc);
        @(negedge clk);
        chk("sb_req", 512'(dmem_req), 512'(1));
        chk("sb_addr", 512'(dmem_addr), 512'(32'h1000));
        chk("sb_wstrb", 512'(dmem_wstrb), 512'(4'b1000));
        chk("sb_wdata", 512'(dmem_wdata), 512'(32'hABABABAB));
        wait_valid(vc);

        // LB / LBU of 0x80 byte
        @(posedge clk); #1;
        rand_fields(); opcode = LD; funct3 = 3'd0; res_R = 32'h1003;
        send(acc); wait_valid(vc);
        chk("lb_sext", 512'(wb_R), 512'(32'hFFFFFF80));
        @(posedge clk); #1;
        rand_fields(); opcode = LD; funct3 = 3'd4; res_R = 32'h1003;
        send(acc); wait_valid(vc);
        chk("lbu_zext", 512'(wb_R), 512'(32'h00000080));

        // LW latency with ack every cycle
        @(posedge clk); #1;
        rand_fields(); opcode = LD; funct3 = 3'd2;
        send(acc); wait_valid(vc);
        chk("lw_latency", 512'(vc - acc), 512'(2));

        // MLOAD wrapping past 2^32 with ack every other cycle
        @(posedge clk); #1;
        ack_mode = 2;
        rand_fields(); opcode = MLD; res_R = 32'hFFFFFFF8;
        send(acc);
        n = 0;
        for (int i = 0; i < 200; i++) begin
            @(negedge clk);
            if (dmem_req && dmem_ack) begin
                if (n < 16) addrs[n] = dmem_addr;
                n++;
            end
            if (valid) break;
        end
        chk("mld_acks", 512'(n), 512'(16));
        chk("mld_valid", 512'(valid), 512'(1));
        chk("mld_a0", 512'(addrs[0]), 512'(32'hFFFFFFF8));
        chk("mld_a1", 512'(addrs[1]), 512'(32'hFFFFFFFC));
        chk("mld_a2", 512'(addrs[2]), 512'(32'h00000000));
        chk("mld_a15", 512'(addrs[15]), 512'(32'h00000034));
        ack_mode = 0;

        // WB back-pressure, then back-to-back accept
        @(posedge clk); #1;
        wb_mode = 1;
        rand_fields(); opcode = 7'b0110011; res_R = 32'h0A0A0A0A;
        send(acc);
        rand_fields(); opcode = 7'b0110011; res_R = 32'h0B0B0B0B;
        EX_valid = 1'b1;
        for (int i = 0; i < 3; i++) begin
            @(negedge clk);
            chk("bp_ready", 512'(ready), 512'(0));
            chk("bp_valid", 512'(valid), 512'(1));
            chk("bp_wbR", 512'(wb_R), 512'(32'h0A0A0A0A));
        end
        @(posedge clk); #1 wb_mode = 0;
        @(negedge clk);
        chk("bp_release_ready", 512'(ready), 512'(1));
        @(posedge clk); #1 EX_valid = 1'b0;
        @(negedge clk);
        chk("b2b_valid", 512'(valid), 512'(1));
        chk("b2b_wbR", 512'(wb_R), 512'(32'h0B0B0B0B));

        // Reset in the middle of an MSTORE (beat 7)
        @(posedge clk); #1;
        rand_fields(); opcode = MST;
        send(acc);
        n = 0;
        for (int i = 0; i < 100; i++) begin
            @(negedge clk);
            if (dmem_req && dmem_ack) n++;
            if (n == 7) break;
        end
        @(posedge clk); #1;
        rst_n = 1'b0; ack_mode = 1;
        @(negedge clk);
        chk("mst_beat7_pending", 512'(dmem_req), 512'(1));
        @(posedge clk); #1 rst_n = 1'b1;
        @(negedge clk);
        chk("abort_req", 512'(dmem_req), 512'(0));
        chk("abort_ready", 512'(ready), 512'(1));
        seen = 1'b0;
        for (int i = 0; i < 20; i++) begin
            @(negedge clk);
            if (valid) seen = 1'b1;
        end
        chk("abort_no_valid", 512'(seen), 512'(0));
        @(posedge clk); #1;
        ack_mode = 0;
        rand_fields(); opcode = LD; funct3 = 3'd2;
        send(acc); wait_valid(vc);
        chk("post_abort_lw", 512'(wb_R), 512'(mem_rd({res_R[31:2], 2'b00})));

        // Random traffic with random ack and WB back-pressure
        @(posedge clk); #1;
        wb_mode = 2; ack_mode = 3;
        for (int t = 0; t < 400; t++) begin
            if ($urandom_range(0, 3) == 0) begin
                repeat ($urandom_range(1, 3)) @(posedge clk);
                #1;
            end
            rand_op();
            send(acc);
        end

        wb_mode = 0; ack_mode = 0;
        for (int i = 0; i < 300; i++) begin
            @(negedge clk);
            if (rq.size() == 0 && !valid) break;
        end
        chk("drain_results", 512'(rq.size()), 512'(0));
        chk("drain_beats", 512'(bq.size()), 512'(0));

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
